// File: rtl/ioctl_dl_router.sv
// Routes ioctl download streams: ROM bytes to dl_* write port, DIP bank and mod byte to registers.
// Optional ROM checksum on dl_sum when IOCTL_DL_CHECKSUM_EN is defined.
module ioctl_dl_router #(
  parameter logic [16:0] ROM_SIZE    = 17'd81920,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter logic [63:0] DIP_DEFAULT = 64'h0
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [16:0] dl_addr,
  output logic [7:0]  dl_data,
  output logic        dl_wr,
  output logic [63:0] sw_bank,
  output logic [7:0]  mod,
  output logic        rom_download,
  output logic        core_reset,
  output logic        dl_done,
  output logic [16:0] dl_bytes,
  output logic        dl_overflow,
  output logic [7:0]  dl_sum
);

  localparam logic [7:0] HoldLast = 8'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StHold} state_e;

  state_e     state;
  logic [7:0] hold_cnt;
  logic       from_load;  // HOLD was entered from LOAD, so its expiry reports dl_done

  logic start_dl, load_entry, rom_wr, rom_ok, rom_accept;

  always_comb begin
    start_dl   = ioctl_download && (ioctl_index == 8'd0);
    load_entry = start_dl && (state != StLoad);
    rom_wr     = ioctl_wr && (state == StLoad) && (ioctl_index == 8'd0);
    rom_ok     = ioctl_addr < {8'd0, ROM_SIZE};
    rom_accept = rom_wr && rom_ok;
  end

  assign rom_download = (state == StLoad);
  assign core_reset   = (state != StIdle);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state       <= StHold;
      hold_cnt    <= 8'd0;
      from_load   <= 1'b0;
      dl_done     <= 1'b0;
      dl_bytes    <= 17'd0;
      dl_overflow <= 1'b0;
    end else begin
      dl_done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start_dl) begin
            state       <= StLoad;
            dl_bytes    <= 17'd0;
            dl_overflow <= 1'b0;
          end
        end
        StLoad: begin
          if (!ioctl_download) begin
            state     <= StHold;
            hold_cnt  <= 8'd0;
            from_load <= 1'b1;
          end
          if (rom_wr) begin
            if (!rom_ok) begin
              dl_overflow <= 1'b1;
            end else if (dl_bytes != 17'h1FFFF) begin
              dl_bytes <= dl_bytes + 17'd1;
            end
          end
        end
        StHold: begin
          // A restart wins over expiry and suppresses the pending dl_done.
          if (start_dl) begin
            state       <= StLoad;
            dl_bytes    <= 17'd0;
            dl_overflow <= 1'b0;
          end else if (hold_cnt == HoldLast) begin
            state     <= StIdle;
            dl_done   <= from_load;
            from_load <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dl_wr   <= 1'b0;
      dl_addr <= 17'd0;
      dl_data <= 8'd0;
    end else begin
      dl_wr <= rom_accept;
      if (rom_accept) begin
        dl_addr <= ioctl_addr[16:0];
        dl_data <= ioctl_dout;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sw_bank <= DIP_DEFAULT;
      mod     <= 8'd0;
    end else if (ioctl_wr) begin
      if ((ioctl_index == 8'd254) && (ioctl_addr[24:3] == 22'd0)) begin
        sw_bank[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
      end
      if (ioctl_index == 8'd1) begin
        mod <= ioctl_dout;
      end
    end
  end

`ifdef IOCTL_DL_CHECKSUM_EN
  logic [7:0] sum_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= 8'd0;
    end else if (load_entry) begin
      sum_q <= 8'd0;
    end else if (rom_accept) begin
      sum_q <= sum_q + ioctl_dout;
    end
  end

  assign dl_sum = sum_q;
`else
  assign dl_sum = 8'h00;
`endif

endmodule

// File: tb/tb_ioctl_dl_router.sv
// Scoreboard bench for ioctl_dl_router: random download/DIP/mod traffic against a byte-level model.
module tb_ioctl_dl_router;

  localparam logic [16:0] ROM_SIZE = 17'd81920;
  localparam int unsigned HOLD     = 16;
  localparam logic [63:0] DIP_DEF  = 64'h0123_4567_89AB_CDEF;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ioctl_download, ioctl_wr;
  logic [7:0]  ioctl_index, ioctl_dout;
  logic [24:0] ioctl_addr;
  logic [16:0] dl_addr, dl_bytes;
  logic [7:0]  dl_data, mod, dl_sum;
  logic        dl_wr, rom_download, core_reset, dl_done, dl_overflow;
  logic [63:0] sw_bank;

  ioctl_dl_router #(
    .ROM_SIZE   (ROM_SIZE),
    .HOLD_CYCLES(HOLD),
    .DIP_DEFAULT(DIP_DEF)
  ) dut (
    .clk_sys       (clk),
    .reset_n       (reset_n),
    .ioctl_download(ioctl_download),
    .ioctl_index   (ioctl_index),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .dl_addr       (dl_addr),
    .dl_data       (dl_data),
    .dl_wr         (dl_wr),
    .sw_bank       (sw_bank),
    .mod           (mod),
    .rom_download  (rom_download),
    .core_reset    (core_reset),
    .dl_done       (dl_done),
    .dl_bytes      (dl_bytes),
    .dl_overflow   (dl_overflow),
    .dl_sum        (dl_sum)
  );

  always #5 clk = ~clk;

  int unsigned cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic [16:0] addr;
    logic [7:0]  data;
    int unsigned cyc;
  } wr_t;

  wr_t         exp_q[$];
  int unsigned done_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  // Reference model state
  logic        in_load = 1'b0;
  int unsigned m_bytes = 0;
  logic [7:0]  m_sum = 8'd0;
  logic        m_ovf = 1'b0;
  logic [7:0]  m_mod = 8'd0;
  logic [7:0]  m_sw[8];
  logic [16:0] last_addr = 17'd0;
  logic [7:0]  last_data = 8'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic logic [63:0] sw_model();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = m_sw[i];
    return v;
  endfunction

  task automatic model_reset();
    in_load   = 1'b0;
    m_bytes   = 0;
    m_sum     = 8'd0;
    m_ovf     = 1'b0;
    m_mod     = 8'd0;
    last_addr = 17'd0;
    last_data = 8'd0;
    for (int i = 0; i < 8; i++) m_sw[i] = DIP_DEF[8*i +: 8];
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write or a done pulse.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (dl_wr) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_dl_wr: got write addr %h data %h, required none", dl_addr,
                   dl_data);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("dl_addr", 64'(dl_addr), 64'(e.addr));
          chk("dl_data", 64'(dl_data), 64'(e.data));
          chk("dl_wr_latency", 64'(cycle), 64'(e.cyc));
          last_addr = e.addr;
          last_data = e.data;
        end
      end else begin
        chk("dl_addr_hold", 64'(dl_addr), 64'(last_addr));
        chk("dl_data_hold", 64'(dl_data), 64'(last_data));
      end
      if (dl_done) begin
        if (done_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_dl_done: got pulse at cycle %0d, required none", cycle);
        end else begin
          chk("dl_done_cycle", 64'(cycle), 64'(done_q.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_wr(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data);
    wr_t e;
    ioctl_index = idx;
    ioctl_addr  = addr;
    ioctl_dout  = data;
    ioctl_wr    = 1'b1;
    if (idx == 8'd0 && in_load) begin
      if (addr < 25'(ROM_SIZE)) begin
        e.addr = addr[16:0];
        e.data = data;
        e.cyc  = cycle + 1;
        exp_q.push_back(e);
        if (m_bytes < 32'h1FFFF) m_bytes++;
        m_sum = m_sum + data;
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (idx == 8'd254 && addr < 25'd8) m_sw[addr[2:0]] = data;
    if (idx == 8'd1) m_mod = data;
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic start_download();
    ioctl_download = 1'b1;
    ioctl_index    = 8'd0;
    tick();
    in_load = 1'b1;
    m_bytes = 0;
    m_sum   = 8'd0;
    m_ovf   = 1'b0;
  endtask

  task automatic end_download_and_wait();
    int n;
    ioctl_download = 1'b0;
    done_q.push_back(cycle + 1 + HOLD);
    tick();
    in_load = 1'b0;
    n = 0;
    while (done_q.size() != 0 && n < int'(HOLD) + 10) begin
      @(negedge clk);
      n++;
    end
    chk("dl_done_seen", 64'(done_q.size()), 64'd0);
    done_q.delete();
  endtask

  task automatic check_model(input string tag);
    logic [7:0] exp_sum;
    @(negedge clk);
`ifdef IOCTL_DL_CHECKSUM_EN
    exp_sum = m_sum;
`else
    exp_sum = 8'd0;
`endif
    chk({tag, "_dl_bytes"}, 64'(dl_bytes), 64'(m_bytes));
    chk({tag, "_dl_sum"}, 64'(dl_sum), 64'(exp_sum));
    chk({tag, "_dl_overflow"}, 64'(dl_overflow), 64'(m_ovf));
    chk({tag, "_sw_bank"}, sw_bank, sw_model());
    chk({tag, "_mod"}, 64'(mod), 64'(m_mod));
    chk({tag, "_rom_download"}, 64'(rom_download), 64'(in_load));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = 25'd0;
    ioctl_dout     = 8'd0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_core_reset", 64'(core_reset), 64'd1);
    chk("rst_dl_wr", 64'(dl_wr), 64'd0);
    chk("rst_dl_addr", 64'(dl_addr), 64'd0);
    chk("rst_dl_done", 64'(dl_done), 64'd0);
    check_model("rst");

    // Release: core_reset must hold for exactly HOLD cycles, with no dl_done.
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    n = 0;
    while (core_reset && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("post_reset_hold_len", 64'(n), 64'(HOLD));

    // Four-byte download
    start_download();
    for (int i = 0; i < 4; i++) do_wr(8'd0, 25'(i), 8'(i + 1));
    end_download_and_wait();
    check_model("dl4");
    chk("dl4_bytes_const", 64'(dl_bytes), 64'd4);
    chk("dl4_core_reset", 64'(core_reset), 64'd0);

    // Out-of-range write sets sticky overflow
    start_download();
    do_wr(8'd0, 25'(ROM_SIZE), 8'h55);
    do_wr(8'd0, 25'(ROM_SIZE) - 25'd1, 8'h66);
    check_model("ovf_load");
    end_download_and_wait();
    check_model("ovf_idle");
    chk("ovf_sticky", 64'(dl_overflow), 64'd1);

    // DIP bank writes, including an ignored address
    do_wr(8'd254, 25'd0, 8'hA5);
    do_wr(8'd254, 25'd2, 8'h3C);
    do_wr(8'd254, 25'd8, 8'hFF);
    do_wr(8'd1, 25'd0, 8'h42);
    check_model("dip");
    chk("dip_const", sw_bank, {DIP_DEF[63:24], 8'h3C, DIP_DEF[15:8], 8'hA5});

    // Restart in HOLD cycle 5: back to LOAD, no dl_done for the aborted hold
    start_download();
    do_wr(8'd0, 25'd100, 8'h11);
    do_wr(8'd0, 25'd101, 8'h22);
    ioctl_download = 1'b0;
    tick();
    in_load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("restart_hold_core_reset", 64'(core_reset), 64'd1);
    end
    start_download();
    chk("restart_core_reset", 64'(core_reset), 64'd1);
    check_model("restart");
    do_wr(8'd0, 25'd7, 8'h33);
    end_download_and_wait();
    check_model("restart_end");

    // Randomized traffic
    for (int it = 0; it < 10; it++) begin
      for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
        case ($urandom_range(0, 3))
          0: do_wr(8'd254, 25'($urandom_range(0, 12)), 8'($urandom));
          1: do_wr(8'd1, 25'($urandom_range(0, 5)), 8'($urandom));
          2: do_wr(8'($urandom_range(2, 253)), 25'($urandom_range(0, 7)), 8'($urandom));
          default: do_wr(8'd0, 25'($urandom_range(0, 99)), 8'($urandom));
        endcase
      end
      start_download();
      for (int b = 0; b < int'($urandom_range(3, 20)); b++) begin
        logic [24:0] a;
        if ($urandom_range(0, 5) == 0)
          a = 25'(32'(ROM_SIZE) + $urandom_range(0, 32'h1FF_FFFF - 32'(ROM_SIZE)));
        else
          a = 25'($urandom_range(0, 32'(ROM_SIZE) - 1));
        do_wr(8'd0, a, 8'($urandom));
        if ($urandom_range(0, 4) == 0) do_wr(8'd254, 25'($urandom_range(0, 9)), 8'($urandom));
        if ($urandom_range(0, 4) == 0) tick();
      end
      ioctl_index = 8'd0;
      check_model("rand_load");
      end_download_and_wait();
      check_model("rand_idle");
      chk("rand_core_reset", 64'(core_reset), 64'd0);
    end

    // Reset mid-LOAD after two bytes
    start_download();
    do_wr(8'd0, 25'd10, 8'hC1);
    do_wr(8'd0, 25'd11, 8'hC2);
    chk("midrst_pending", 64'(exp_q.size()), 64'd1);
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    #1;
    chk("midrst_dl_wr", 64'(dl_wr), 64'd0);
    chk("midrst_dl_bytes", 64'(dl_bytes), 64'd0);
    chk("midrst_core_reset", 64'(core_reset), 64'd1);
    chk("midrst_rom_download", 64'(rom_download), 64'd0);
    void'(exp_q.pop_back());
    model_reset();
    tick();
    tick();
    reset_n = 1'b1;
    repeat (HOLD + 4) tick();
    chk("midrst_idle", 64'(core_reset), 64'd0);
    check_model("midrst");

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ioctl_dl_router.md
IOCTL_DL_ROUTER -- requirements
Module: ioctl_dl_router

Interface
REQ-001 SHALL provide parameter ROM_SIZE, default 17'd81920: number of ROM bytes accepted per download; addresses at or above it are rejected.
REQ-002 SHALL provide parameter HOLD_CYCLES, default 16: number of cycles core_reset stays asserted after a download ends or reset is released (1..255).
REQ-003 SHALL provide parameter DIP_DEFAULT, default 64'h0: reset value of sw_bank.
REQ-004 clk_sys  in  1  system clock; all logic rising-edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 ioctl_download  in  1  download in progress.
REQ-007 ioctl_index  in  8  stream index: 0 ROM, 1 mod byte, 254 DIP bank.
REQ-008 ioctl_wr  in  1  one-cycle byte strobe.
REQ-009 ioctl_addr  in  25  byte address.
REQ-010 ioctl_dout  in  8  byte data.
REQ-011 dl_addr  out  17  ROM write address.
REQ-012 dl_data  out  8  ROM write data.
REQ-013 dl_wr  out  1  ROM write strobe, one cycle.
REQ-014 sw_bank  out  64  DIP bytes; byte n at bits [8n+7:8n].
REQ-015 mod  out  8  game variant byte.
REQ-016 rom_download  out  1  high while in state LOAD.
REQ-017 core_reset  out  1  game core reset, high in any state except IDLE.
REQ-018 dl_done  out  1  one-cycle pulse when a ROM download's hold completes.
REQ-019 dl_bytes  out  17  accepted ROM bytes in current/last download.
REQ-020 dl_overflow  out  1  sticky: a ROM write at or above ROM_SIZE was rejected.
REQ-021 dl_sum  out  8  ROM byte checksum (see Configuration).

Function
REQ-022 State machine SHALL have states IDLE, LOAD, HOLD, with a hold counter.
REQ-023 IDLE -> LOAD when ioctl_download=1 and ioctl_index=0; entry clears dl_bytes, dl_overflow, dl_sum.
REQ-024 LOAD -> HOLD when ioctl_download=0; counter loads 0.
REQ-025 HOLD -> IDLE when counter reaches HOLD_CYCLES-1; otherwise counter increments.
REQ-026 HOLD -> LOAD when a new index-0 download starts; this takes priority over hold expiry, with the same clears as REQ-023.
REQ-027 dl_done SHALL pulse on the HOLD->IDLE cycle only when HOLD was entered from LOAD, not after reset.
REQ-028 A ROM write is accepted when ioctl_wr=1, state=LOAD, ioctl_index=0 and ioctl_addr<ROM_SIZE.
REQ-029 On acceptance dl_wr=1 the next cycle with dl_addr=ioctl_addr[16:0] and dl_data=ioctl_dout (latency 1); dl_addr/dl_data hold otherwise.
REQ-030 dl_bytes SHALL increment per accepted write and saturate at 17'h1FFFF.
REQ-031 A ROM write with ioctl_addr>=ROM_SIZE SHALL produce no dl_wr and SHALL set dl_overflow.
REQ-032 DIP write: ioctl_wr=1, ioctl_index=254, ioctl_addr[24:3]=0 -> sw_bank byte ioctl_addr[2:0] updated next cycle, in any state; other addresses ignored.
REQ-033 mod write: ioctl_wr=1, ioctl_index=1 -> mod=ioctl_dout next cycle, in any state; last write wins.
REQ-034 ioctl_wr with any other index SHALL be ignored.

Reset
REQ-035 reset_n=0 SHALL asynchronously force state HOLD, counter 0, dl_wr 0, dl_addr 0, dl_data 0, dl_bytes 0, dl_overflow 0, dl_sum 0, dl_done 0, mod 0, sw_bank DIP_DEFAULT; core_reset=1, rom_download=0.
REQ-036 After release, core_reset SHALL stay 1 for HOLD_CYCLES cycles, then IDLE with no dl_done pulse.
REQ-037 Reset asserted mid-LOAD SHALL abort the download without producing a dl_done pulse.

Configuration
REQ-038 With IOCTL_DL_CHECKSUM_EN defined, dl_sum SHALL be the modulo-256 sum of accepted ROM bytes, updated with dl_wr; it is cleared at LOAD entry.
REQ-039 Without IOCTL_DL_CHECKSUM_EN, dl_sum SHALL be constant 0 and no adder is synthesized.

Verification
REQ-040 Release reset, HOLD_CYCLES=16 -> core_reset high 16 cycles, then low; no dl_done.
REQ-041 Index-0 download of 4 bytes 01,02,03,04 at addr 0..3 -> four dl_wr pulses, each 1 cycle after ioctl_wr; dl_bytes=4; dl_sum=0x0A (macro on) or 0 (macro off); dl_done 16 cycles after ioctl_download falls.
REQ-042 Write to addr 81920 during LOAD -> no dl_wr; dl_overflow=1 until next LOAD entry.
REQ-043 Index 254 writes at addr 0=0xA5, 2=0x3C, 8=0xFF -> sw_bank[7:0]=A5, [23:16]=3C, rest DIP_DEFAULT.
REQ-044 New download started at HOLD cycle 5 -> state LOAD, dl_bytes cleared, core_reset stays high, no dl_done.
REQ-045 reset_n low during LOAD after 2 bytes -> dl_wr 0 immediately, dl_bytes 0, no dl_done.
